// File: rtl/zone_alarm_ctrl.sv
// Multi-zone intrusion alarm controller: synchronised zone sensors, keypad events,
// exit/entry/siren timing on one shared down-counter, and cause-zone memory.
module zone_alarm_ctrl #(
    parameter int                 N_ZONES      = 4,
    parameter logic [N_ZONES-1:0] DELAY_MASK   = 4'b0001,
    parameter int                 TIMER_W      = 18,
    parameter int                 EXIT_CYCLES  = 150000,
    parameter int                 ENTRY_CYCLES = 150000,
    parameter int                 SIREN_CYCLES = 262143,
    parameter int                 MAX_ERRORS   = 3
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [N_ZONES-1:0] SENSOR_IN,
    input  logic [1:0]         KEY_STATUS,
    output logic               SIREN_OUT,
    output logic               BEEP_OUT,
    output logic [2:0]         STATE_OUT,
    output logic [N_ZONES-1:0] ZONE_MEM,
    output logic [N_ZONES+1:0] STATUS_MSG
);

    typedef enum logic [2:0] {
        DISARMED     = 3'd0,
        EXIT_DELAY   = 3'd1,
        ARMED        = 3'd2,
        ENTRY_DELAY  = 3'd3,
        ALARM        = 3'd4,
        ALARM_SILENT = 3'd5
    } state_t;

    localparam logic [TIMER_W-1:0] EXIT_LD  = TIMER_W'(EXIT_CYCLES - 1);
    localparam logic [TIMER_W-1:0] ENTRY_LD = TIMER_W'(ENTRY_CYCLES - 1);
    localparam logic [TIMER_W-1:0] SIREN_LD = TIMER_W'(SIREN_CYCLES - 1);
    localparam logic [2:0]         ERR_LIM  = 3'(MAX_ERRORS);

    state_t             state, state_n;
    logic [N_ZONES-1:0] s_meta, s, s_prev;
    logic [1:0]         prev_key;
    logic [TIMER_W-1:0] cnt, load_val;
    logic               load;
    logic [2:0]         err_cnt, err_n, err_sum;
    logic [N_ZONES-1:0] zmem_n;
    logic               ok_evt, err_evt, inst, dly, rise, expire, err_inc, err_lim;

    assign ok_evt  = (KEY_STATUS == 2'd0) && (prev_key != 2'd0);
    assign err_evt = (KEY_STATUS == 2'd2) && (prev_key != 2'd2);
    assign inst    = |(s & ~DELAY_MASK);
    assign dly     = |(s & DELAY_MASK);
    assign rise    = |(s & ~s_prev);
    assign expire  = (state inside {EXIT_DELAY, ENTRY_DELAY, ALARM}) && (cnt == '0);
    // Wrong codes only count while the system is armed or arming.
    assign err_inc = err_evt && (state inside {EXIT_DELAY, ARMED, ENTRY_DELAY});
    assign err_sum = err_cnt + 3'd1;
    assign err_lim = err_inc && (err_sum >= ERR_LIM);

    always_comb begin
        state_n  = state;
        load     = 1'b0;
        load_val = '0;
        err_n    = err_inc ? err_sum : err_cnt;
        zmem_n   = ZONE_MEM;
        case (state)
            DISARMED: if (ok_evt) begin
                state_n  = EXIT_DELAY;
                load     = 1'b1;
                load_val = EXIT_LD;
                zmem_n   = '0;
            end
            EXIT_DELAY: begin
                if (ok_evt)               state_n = DISARMED;
                else if (err_lim || inst) state_n = ALARM;
                else if (expire && dly) begin
                    state_n  = ENTRY_DELAY;
                    load     = 1'b1;
                    load_val = ENTRY_LD;
                end else if (expire)      state_n = ARMED;
            end
            ARMED: begin
                if (ok_evt)               state_n = DISARMED;
                else if (err_lim || inst) state_n = ALARM;
                else if (dly) begin
                    state_n  = ENTRY_DELAY;
                    load     = 1'b1;
                    load_val = ENTRY_LD;
                end
            end
            ENTRY_DELAY: begin
                if (ok_evt)                         state_n = DISARMED;
                else if (err_lim || inst || expire) state_n = ALARM;
            end
            ALARM: begin
                if (ok_evt)      state_n = DISARMED;
                else if (expire) state_n = ALARM_SILENT;
            end
            ALARM_SILENT: begin
                if (ok_evt)    state_n = DISARMED;
                else if (rise) state_n = ALARM;
            end
            default: state_n = DISARMED;
        endcase
        // Every way into ALARM (including a silent retrigger) restarts the siren.
        if (state_n == ALARM && state != ALARM) begin
            load     = 1'b1;
            load_val = SIREN_LD;
            err_n    = '0;
            zmem_n   = ZONE_MEM | s;
        end
        if (ok_evt || (state_n == DISARMED && state != DISARMED)) err_n = '0;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= DISARMED;
            s_meta     <= '0;
            s          <= '0;
            s_prev     <= '0;
            prev_key   <= 2'd3;
            cnt        <= '0;
            err_cnt    <= '0;
            ZONE_MEM   <= '0;
            STATUS_MSG <= '0;
        end else begin
            state      <= state_n;
            s_meta     <= SENSOR_IN;
            s          <= s_meta;
            s_prev     <= s;
            prev_key   <= KEY_STATUS;
            err_cnt    <= err_n;
            ZONE_MEM   <= zmem_n;
            STATUS_MSG <= {state != DISARMED, state inside {ALARM, ALARM_SILENT}, s};
            if (load)            cnt <= load_val;
            else if (cnt != '0)  cnt <= cnt - 1'b1;
        end
    end

    assign SIREN_OUT = (state == ALARM);
    assign BEEP_OUT  = (state == EXIT_DELAY) || (state == ENTRY_DELAY);
    assign STATE_OUT = state;

endmodule

// File: tb/tb_zone_alarm_ctrl.sv
// Bench for zone_alarm_ctrl: directed scenarios with literal expectations, then
// randomized keypad/sensor/reset traffic, all checked every cycle against a reference model.
module tb_zone_alarm_ctrl;

    localparam int NZ    = 4;
    localparam logic [NZ-1:0] DM = 4'b0001;
    localparam int EXITC = 8;
    localparam int ENTC  = 6;
    localparam int SIRC  = 10;
    localparam int MAXE  = 3;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic [NZ-1:0] SENSOR_IN = '0;
    logic [1:0]    KEY_STATUS = 2'd3;
    logic          SIREN_OUT, BEEP_OUT;
    logic [2:0]    STATE_OUT;
    logic [NZ-1:0] ZONE_MEM;
    logic [NZ+1:0] STATUS_MSG;

    int vectors = 0;
    int miscompares = 0;

    zone_alarm_ctrl #(
        .N_ZONES(NZ), .DELAY_MASK(DM), .TIMER_W(18), .EXIT_CYCLES(EXITC),
        .ENTRY_CYCLES(ENTC), .SIREN_CYCLES(SIRC), .MAX_ERRORS(MAXE)
    ) dut (
        .CLK(CLK), .RST(RST), .SENSOR_IN(SENSOR_IN), .KEY_STATUS(KEY_STATUS),
        .SIREN_OUT(SIREN_OUT), .BEEP_OUT(BEEP_OUT), .STATE_OUT(STATE_OUT),
        .ZONE_MEM(ZONE_MEM), .STATUS_MSG(STATUS_MSG)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, wanted %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: states as small integers, the timer as "cycles left in this state",
    // sensors delayed through a two-entry history.
    int            m_state, m_left, m_err;
    logic [NZ-1:0] m_h1, m_s, m_sprev, m_zmem;
    logic [NZ+1:0] m_msg;
    logic [1:0]    m_pk;

    function automatic int dur(input int st);
        return (st == 1) ? EXITC : (st == 3) ? ENTC : SIRC;
    endfunction

    always @(posedge CLK) begin
        if (RST) begin
            m_state = 0; m_left = 0; m_err = 0; m_h1 = '0; m_s = '0;
            m_sprev = '0; m_zmem = '0; m_msg = '0; m_pk = 2'd3;
        end else begin
            bit ok, er, armish, expire, win, door, edge_up;
            int e, ns;
            ok      = (KEY_STATUS == 0) && (m_pk != 0);
            er      = (KEY_STATUS == 2) && (m_pk != 2);
            win     = |(m_s & ~DM);
            door    = |(m_s & DM);
            edge_up = |(m_s & ~m_sprev);
            armish  = (m_state >= 1 && m_state <= 3);
            e       = m_err + ((er && armish) ? 1 : 0);
            expire  = (m_state == 1 || m_state == 3 || m_state == 4) && (m_left == 1);
            ns = m_state;
            if (ok)                      ns = (m_state == 0) ? 1 : 0;
            else if (armish && e >= MAXE) ns = 4;
            else if (armish && win)       ns = 4;
            else if (m_state == 1 && expire) ns = door ? 3 : 2;
            else if (m_state == 2 && door)   ns = 3;
            else if (m_state == 3 && expire) ns = 4;
            else if (m_state == 4 && expire) ns = 5;
            else if (m_state == 5 && edge_up) ns = 4;
            m_msg = {m_state != 0, m_state == 4 || m_state == 5, m_s};
            if (ok || (ns == 0 && m_state != 0) || (ns == 4 && m_state != 4)) e = 0;
            if (m_state == 0 && ns == 1) m_zmem = '0;
            if (ns == 4 && m_state != 4) m_zmem = m_zmem | m_s;
            if (ns != m_state && (ns == 1 || ns == 3 || ns == 4)) m_left = dur(ns);
            else if (m_left > 0) m_left = m_left - 1;
            m_err = e;
            m_state = ns;
            m_pk = KEY_STATUS;
            m_sprev = m_s;
            m_s = m_h1;
            m_h1 = SENSOR_IN;
        end
        #1;
        chk("state", int'(STATE_OUT), m_state);
        chk("siren", int'(SIREN_OUT), int'(m_state == 4));
        chk("beep", int'(BEEP_OUT), int'(m_state == 1 || m_state == 3));
        chk("zone_mem", int'(ZONE_MEM), int'(m_zmem));
        chk("status_msg", int'(STATUS_MSG), int'(m_msg));
    end

    task automatic press(input logic [1:0] k);
        @(negedge CLK) KEY_STATUS = k;
        @(negedge CLK) KEY_STATUS = 2'd3;
        @(negedge CLK);
    endtask

    task automatic wait_state(input int t, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (int'(STATE_OUT) == t) break;
            @(negedge CLK);
        end
        chk("wait_state", int'(STATE_OUT), t);
    endtask

    task automatic arm();
        press(2'd0);
        wait_state(2, 20);
    endtask

    int n_a, n_b;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge CLK);
        chk("rst_state", int'(STATE_OUT), 0);
        chk("rst_siren", int'(SIREN_OUT), 0);
        chk("rst_msg", int'(STATUS_MSG), 0);
        RST = 1'b0;

        // Arm with a held OK: exactly one event, 8 cycles of exit delay/beep.
        @(negedge CLK) KEY_STATUS = 2'd0;
        n_a = 0; n_b = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge CLK);
            if (STATE_OUT == 3'd1) n_a++;
            if (BEEP_OUT) n_b++;
            if (i == 5) KEY_STATUS = 2'd3;
        end
        chk("exit_len", n_a, 8);
        chk("beep_len", n_b, 8);
        chk("armed", int'(STATE_OUT), 2);

        // Door entry with no code: 6 entry cycles, 10 siren cycles, then silent.
        SENSOR_IN = 4'b0001;
        n_a = 0; n_b = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if (STATE_OUT == 3'd3) n_a++;
            if (SIREN_OUT) n_b++;
        end
        chk("entry_len", n_a, 6);
        chk("siren_len", n_b, 10);
        chk("silent", int'(STATE_OUT), 5);
        chk("zmem_door", int'(ZONE_MEM), 1);
        press(2'd0);
        SENSOR_IN = '0;
        wait_state(0, 5);

        // OK arriving on the entry-expiry cycle disarms; siren never fires.
        arm();
        SENSOR_IN = 4'b0001;
        wait_state(3, 10);
        repeat (5) @(negedge CLK);
        KEY_STATUS = 2'd0;
        @(negedge CLK);
        KEY_STATUS = 2'd3;
        chk("boundary_disarm", int'(STATE_OUT), 0);
        n_b = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge CLK);
            if (SIREN_OUT) n_b++;
        end
        chk("boundary_siren", n_b, 0);
        SENSOR_IN = '0;

        // Window during exit delay trips instantly.
        press(2'd0);
        wait_state(1, 5);
        repeat (2) @(negedge CLK);
        SENSOR_IN = 4'b0100;
        wait_state(4, 10);
        chk("zmem_window", int'(ZONE_MEM), 4);
        press(2'd0);
        SENSOR_IN = '0;
        wait_state(0, 5);

        // Door during exit delay is held off until expiry, then entry delay.
        press(2'd0);
        wait_state(1, 5);
        chk("zmem_cleared", int'(ZONE_MEM), 0);
        SENSOR_IN = 4'b0001;
        for (int i = 0; i < 20; i++) begin
            if (STATE_OUT != 3'd1) break;
            @(negedge CLK);
        end
        chk("exit_door", int'(STATE_OUT), 3);
        press(2'd0);
        SENSOR_IN = '0;
        wait_state(0, 5);

        // Wrong codes.
        arm();
        press(2'd2);
        press(2'd2);
        chk("two_errs", int'(STATE_OUT), 2);
        press(2'd2);
        chk("three_errs", int'(STATE_OUT), 4);
        press(2'd0);
        wait_state(0, 5);
        arm();
        press(2'd2);
        press(2'd2);
        press(2'd0);
        wait_state(0, 5);
        arm();
        press(2'd2);
        press(2'd2);
        chk("err_cleared", int'(STATE_OUT), 2);
        press(2'd0);
        wait_state(0, 5);
        press(2'd2);
        press(2'd2);
        press(2'd2);
        chk("errs_disarmed", int'(STATE_OUT), 0);

        // Silent retrigger, then reset mid-alarm.
        arm();
        SENSOR_IN = 4'b0100;
        wait_state(5, 40);
        SENSOR_IN = 4'b0110;
        n_b = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (SIREN_OUT) n_b++;
        end
        chk("retrigger_siren", n_b, 10);
        chk("zmem_retrigger", int'(ZONE_MEM), 6);
        SENSOR_IN = 4'b0111;
        wait_state(4, 6);
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        chk("rst_mid_state", int'(STATE_OUT), 0);
        chk("rst_mid_siren", int'(SIREN_OUT), 0);
        RST = 1'b0;
        SENSOR_IN = '0;

        // Random traffic against the model.
        n_a = 0;
        for (int i = 0; i < 1200; i++) begin
            int r, b;
            @(negedge CLK);
            if (n_a == 0) begin
                r = $urandom_range(0, 99);
                KEY_STATUS = (r < 55) ? 2'd3 : (r < 75) ? 2'd0 : (r < 93) ? 2'd2 : 2'd1;
                n_a = $urandom_range(1, 3);
            end
            n_a--;
            if ($urandom_range(0, 6) == 0) begin
                b = $urandom_range(0, NZ - 1);
                SENSOR_IN[b] = ~SENSOR_IN[b];
            end
            RST = ($urandom_range(0, 249) == 0);
        end
        @(negedge CLK);
        RST = 1'b0;
        repeat (2) @(negedge CLK);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
